// File: rtl/mont_mul_arbiter.sv
// -----------------------------------------------------------------------------
// mont_mul_arbiter
//
// Shares one montMul instance between two requesters with round-robin
// arbitration. Latches the owner's operands at grant, issues a one-cycle
// start pulse, waits for the multiplier's finished flag, then returns the
// latched result with a one-cycle done strobe to the owner only.
//
// Ports
//   i_clk, i_rst             clock (rising edge), async active-high reset
//   i_req[1:0]               request level, bit k = requester k
//   i_a0/i_b0/i_n0           requester 0 operands (stable while i_req[0])
//   i_a1/i_b1/i_n1           requester 1 operands (stable while i_req[1])
//   o_grant[1:0]             one-hot owner, 0 when idle
//   o_done[1:0]              one-cycle result strobe to the owner
//   o_result                 latched result, held until the next result
//   o_busy                   high whenever not IDLE
//   o_mul_start              start pulse to montMul
//   o_mul_a/o_mul_b/o_mul_n  latched operands to montMul
//   i_mul_result             montMul result
//   i_mul_finished           montMul finished flag
// -----------------------------------------------------------------------------
module mont_mul_arbiter #(
   parameter int WIDTH = 256
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [1:0]       i_req,
   input  logic [WIDTH-1:0] i_a0,
   input  logic [WIDTH-1:0] i_b0,
   input  logic [WIDTH-1:0] i_n0,
   input  logic [WIDTH-1:0] i_a1,
   input  logic [WIDTH-1:0] i_b1,
   input  logic [WIDTH-1:0] i_n1,
   output logic [1:0]       o_grant,
   output logic [1:0]       o_done,
   output logic [WIDTH-1:0] o_result,
   output logic             o_busy,
   output logic             o_mul_start,
   output logic [WIDTH-1:0] o_mul_a,
   output logic [WIDTH-1:0] o_mul_b,
   output logic [WIDTH-1:0] o_mul_n,
   input  logic [WIDTH-1:0] i_mul_result,
   input  logic             i_mul_finished
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_owner;
   logic             r_last;
   logic [1:0]       r_grant;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_n;
   logic [WIDTH-1:0] r_result;

   logic             w_take;
   logic             w_pick;

   // Arbitration: on contention the requester that was not served last wins.
   always_comb begin
      w_take = 1'b0;
      w_pick = 1'b0;
      case (i_req)
         2'b01: begin w_take = 1'b1; w_pick = 1'b0;    end
         2'b10: begin w_take = 1'b1; w_pick = 1'b1;    end
         2'b11: begin w_take = 1'b1; w_pick = ~r_last; end
         default: begin w_take = 1'b0; w_pick = 1'b0;  end
      endcase
   end

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; i_mul_finished only matters in WAIT
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_take) w_next = S_ISSUE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (i_mul_finished) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath and bookkeeping registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_owner  <= 1'b0;
         r_last   <= 1'b1;          // requester 0 wins the first contention
         r_grant  <= 2'b00;
         r_a      <= '0;
         r_b      <= '0;
         r_n      <= '0;
         r_result <= '0;
      end else begin
         if (r_state == S_IDLE && w_take) begin
            r_owner <= w_pick;
            r_grant <= w_pick ? 2'b10 : 2'b01;
            r_a     <= w_pick ? i_a1 : i_a0;
            r_b     <= w_pick ? i_b1 : i_b0;
            r_n     <= w_pick ? i_n1 : i_n0;
         end
         if (r_state == S_WAIT && i_mul_finished) begin
            r_result <= i_mul_result;
         end
         if (r_state == S_DONE) begin
            r_last  <= r_owner;
            r_grant <= 2'b00;
         end
      end
   end

   // Outputs decoded from registered state only; no path from i_req
   always_comb begin
      o_mul_start = (r_state == S_ISSUE);
      o_busy      = (r_state != S_IDLE);
      o_done      = 2'b00;
      if (r_state == S_DONE) begin
         o_done = r_owner ? 2'b10 : 2'b01;
      end
   end

   assign o_grant  = r_grant;
   assign o_result = r_result;
   assign o_mul_a  = r_a;
   assign o_mul_b  = r_b;
   assign o_mul_n  = r_n;

endmodule
